// File: rtl/display_pkg.sv
// Shared constants, state encoding and the BCD-to-7-segment decoder used by
// the display controller and its bench.
package display_pkg;

    localparam logic [7:0] SEG_A     = 8'h01;
    localparam logic [7:0] SEG_B     = 8'h02;
    localparam logic [7:0] SEG_C     = 8'h04;
    localparam logic [7:0] SEG_D     = 8'h08;
    localparam logic [7:0] SEG_E     = 8'h10;
    localparam logic [7:0] SEG_F     = 8'h20;
    localparam logic [7:0] SEG_G     = 8'h40;
    localparam logic [7:0] SEG_DOT   = 8'h80;
    localparam logic [7:0] SEG_MINUS = SEG_G;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    function automatic logic [7:0] bcd_to_segments(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            4'd1:    s = SEG_B | SEG_C;
            4'd2:    s = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
            4'd3:    s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
            4'd4:    s = SEG_B | SEG_C | SEG_F | SEG_G;
            4'd5:    s = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
            4'd6:    s = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'd7:    s = SEG_A | SEG_B | SEG_C;
            4'd8:    s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'd9:    s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble: i_start loads the magnitude, then eight add-3/shift
// cycles follow. o_done flags the cycle whose edge performs the final shift.
module bin_to_bcd_serial
    import display_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_mag,
    output logic [11:0] o_bcd,
    output logic        o_done
);

    logic [11:0] r_bcd;
    logic [7:0]  r_mag;
    logic [2:0]  r_cnt;
    logic        r_run;
    logic [11:0] w_adj;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign w_adj  = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    assign o_bcd  = r_bcd;
    assign o_done = r_run && (r_cnt == 3'd7);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bcd <= '0;
            r_mag <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_bcd <= '0;
            r_mag <= i_mag;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_bcd <= {w_adj[10:0], r_mag[7]};
            r_mag <= {r_mag[6:0], 1'b0};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7)
                r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/display_controller.sv
// 4x7-segment controller: captures a value, converts it serially to BCD,
// commits it atomically to shadow digits and scans them with a prescaler.
module display_controller
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_value,
    input  logic       i_signed_mode,
    output logic       o_busy,
    output logic [7:0] o_segments,
    output logic [3:0] o_digit
);

    localparam int              PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_TC = PW'(SCAN_DIV - 1);

    state_t        r_state;
    logic          r_neg_cap;
    logic          r_sign;
    logic [3:0]    r_ones;
    logic [3:0]    r_tens;
    logic [3:0]    r_hund;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_digit;
    logic [1:0]    r_idx;

    logic          w_start;
    logic          w_neg;
    logic [7:0]    w_mag;
    logic [11:0]   w_bcd;
    logic          w_done;
    logic          w_hund_blank;
    logic          w_tens_blank;

    assign w_start = i_load && (r_state == IDLE);
    assign w_neg   = i_signed_mode && i_value[7];
    // 8'h80 negates to 8'h80, which reads correctly as unsigned 128.
    assign w_mag   = w_neg ? (~i_value + 8'd1) : i_value;
    assign o_busy  = (r_state != IDLE);
    assign o_digit = r_digit;

    bin_to_bcd_serial u_b2b (
        .i_clk   (i_sys_clk),
        .i_rst   (i_rst),
        .i_start (w_start),
        .i_mag   (w_mag),
        .o_bcd   (w_bcd),
        .o_done  (w_done)
    );

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_neg_cap <= 1'b0;
            r_sign    <= 1'b0;
            r_ones    <= '0;
            r_tens    <= '0;
            r_hund    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_neg_cap <= w_neg;
                        r_state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (w_done)
                        r_state <= COMMIT;
                end
                COMMIT: begin
                    r_ones  <= w_bcd[3:0];
                    r_tens  <= w_bcd[7:4];
                    r_hund  <= w_bcd[11:8];
                    r_sign  <= r_neg_cap;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan is independent of the FSM so the display never stalls mid-conversion.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
            r_digit <= 4'b0001;
            r_idx   <= 2'd0;
        end else if (r_presc == PRESC_TC) begin
            r_presc <= '0;
            r_digit <= {r_digit[2:0], r_digit[3]};
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_hund_blank = BLANK_LZ && (r_hund == 4'd0);
    assign w_tens_blank = BLANK_LZ && (r_hund == 4'd0) && (r_tens == 4'd0);

    always_comb begin
        o_segments = SEG_BLANK;
        case (r_idx)
            2'd0: o_segments = bcd_to_segments(r_ones);
            2'd1: o_segments = w_tens_blank ? SEG_BLANK : bcd_to_segments(r_tens);
            2'd2: o_segments = w_hund_blank ? SEG_BLANK : bcd_to_segments(r_hund);
            2'd3: o_segments = r_sign ? SEG_MINUS : SEG_BLANK;
            default: o_segments = SEG_BLANK;
        endcase
    end

endmodule
